// File: rtl/sram_arbiter.sv
// Two-master arbiter (instruction fetch, data memory) in front of the single-port SRAM controller.
// Optional build macro SRAM_ARB_RR_EN: alternate grants on simultaneous requests instead of fixed data priority.
module sram_arbiter #(
    parameter int ADDR_W         = 20,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              inst_req_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    output logic [31:0]       inst_rdata_o,
    output logic              inst_ready_o,
    input  logic [3:0]        data_op_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              data_ready_o,
    output logic [3:0]        ram_op_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic              ram_success_i,
    output logic              stall_o,
    output logic              timeout_o
);

    // Op encodings mirror the MEM_* codes shared with the pipeline.
    localparam logic [3:0] MEM_NOP  = 4'b0000;
    localparam logic [3:0] MEM_LW   = 4'b0101;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_I  = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [3:0]          r_ram_op,    w_ram_op_nx;
    logic [ADDR_W-1:0]   r_ram_addr,  w_ram_addr_nx;
    logic [31:0]         r_ram_wdata, w_ram_wdata_nx;
    logic [7:0]          r_cnt,       w_cnt_nx;
    logic [31:0]         r_inst_rdata, w_inst_rdata_nx;
    logic [31:0]         r_data_rdata, w_data_rdata_nx;
    logic                r_inst_ready, w_inst_ready_nx;
    logic                r_data_ready, w_data_ready_nx;
    logic                r_timeout,    w_timeout_nx;
    logic                w_data_req;
    logic                w_grant_d;
    logic                w_grant_i;

    assign w_data_req = (data_op_i != MEM_NOP);

`ifdef SRAM_ARB_RR_EN
    logic r_last_d;

    // Grant selection: on a tie, give the port that did not win last time.
    always_comb begin
        w_grant_d = 1'b0;
        if (w_data_req && inst_req_i) begin
            w_grant_d = ~r_last_d;
        end else begin
            w_grant_d = w_data_req;
        end
        w_grant_i = inst_req_i & ~w_grant_d;
    end

    // Last-grant memory; resets to "fetch" so the first tie goes to data.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if ((r_state == ST_IDLE) && (w_grant_d || w_grant_i)) begin
            r_last_d <= w_grant_d;
        end else begin
            r_last_d <= r_last_d;
        end
    end
`else
    // Grant selection: fixed data-over-fetch priority.
    always_comb begin
        w_grant_d = w_data_req;
        w_grant_i = inst_req_i & ~w_data_req;
    end
`endif

    // Next-state and next-output logic; pulses default low, captured regs hold.
    always_comb begin
        w_state_nx      = r_state;
        w_ram_op_nx     = r_ram_op;
        w_ram_addr_nx   = r_ram_addr;
        w_ram_wdata_nx  = r_ram_wdata;
        w_cnt_nx        = r_cnt;
        w_inst_rdata_nx = r_inst_rdata;
        w_data_rdata_nx = r_data_rdata;
        w_inst_ready_nx = 1'b0;
        w_data_ready_nx = 1'b0;
        w_timeout_nx    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = 8'd0;
                if (w_grant_d) begin
                    w_ram_op_nx    = data_op_i;
                    w_ram_addr_nx  = data_addr_i;
                    w_ram_wdata_nx = data_wdata_i;
                    w_state_nx     = ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_ram_op_nx    = MEM_LW;
                    w_ram_addr_nx  = inst_addr_i;
                    w_ram_wdata_nx = 32'h0000_0000;
                    w_state_nx     = ST_BUSY_I;
                end else begin
                    w_ram_op_nx = MEM_NOP;
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (ram_success_i || (r_cnt == CNT_LAST)) begin
                    // Completion or abort: answer the granted port next cycle.
                    w_ram_op_nx  = MEM_NOP;
                    w_cnt_nx     = 8'd0;
                    w_state_nx   = ST_RELEASE;
                    w_timeout_nx = ~ram_success_i;
                    if (r_state == ST_BUSY_D) begin
                        w_data_rdata_nx = ram_success_i ? ram_rdata_i : 32'h0000_0000;
                        w_data_ready_nx = 1'b1;
                    end else begin
                        w_inst_rdata_nx = ram_success_i ? ram_rdata_i : 32'h0000_0000;
                        w_inst_ready_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            ST_RELEASE: begin
                w_ram_op_nx = MEM_NOP;
                w_cnt_nx    = 8'd0;
                w_state_nx  = ST_IDLE;
            end
            default: begin
                w_ram_op_nx = MEM_NOP;
                w_cnt_nx    = 8'd0;
                w_state_nx  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ram_op     <= MEM_NOP;
            r_ram_addr   <= {ADDR_W{1'b0}};
            r_ram_wdata  <= 32'h0000_0000;
            r_cnt        <= 8'd0;
            r_inst_rdata <= 32'h0000_0000;
            r_data_rdata <= 32'h0000_0000;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_ram_op     <= w_ram_op_nx;
            r_ram_addr   <= w_ram_addr_nx;
            r_ram_wdata  <= w_ram_wdata_nx;
            r_cnt        <= w_cnt_nx;
            r_inst_rdata <= w_inst_rdata_nx;
            r_data_rdata <= w_data_rdata_nx;
            r_inst_ready <= w_inst_ready_nx;
            r_data_ready <= w_data_ready_nx;
            r_timeout    <= w_timeout_nx;
        end
    end

    assign ram_op_o     = r_ram_op;
    assign ram_addr_o   = r_ram_addr;
    assign ram_wdata_o  = r_ram_wdata;
    assign inst_rdata_o = r_inst_rdata;
    assign inst_ready_o = r_inst_ready;
    assign data_rdata_o = r_data_rdata;
    assign data_ready_o = r_data_ready;
    assign timeout_o    = r_timeout;
    assign stall_o      = (inst_req_i & ~r_inst_ready) | (w_data_req & ~r_data_ready);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized traffic
// against a transaction-level schedule model and a behavioural SRAM controller.
module tb_sram_arbiter;

    localparam int         AW    = 20;
    localparam int         TO    = 15;
    localparam logic [3:0] OP_LW = 4'b0101;
    localparam logic [3:0] OP_SW = 4'b1000;

    logic          clk50 = 1'b0;
    logic          rst;
    logic          inst_req_i;
    logic [AW-1:0] inst_addr_i;
    logic [31:0]   inst_rdata_o;
    logic          inst_ready_o;
    logic [3:0]    data_op_i;
    logic [AW-1:0] data_addr_i;
    logic [31:0]   data_wdata_i;
    logic [31:0]   data_rdata_o;
    logic          data_ready_o;
    logic [3:0]    ram_op_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i;
    logic          ram_success_i;
    logic          stall_o;
    logic          timeout_o;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          sram_lat = 99;
    int          sram_age = 0;
    logic [31:0] sram_data = 32'h0000_0000;
    bit          noise_en = 1'b0;

    sram_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk50(clk50), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_ready_o(inst_ready_o),
        .data_op_i(data_op_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_ready_o(data_ready_o),
        .ram_op_o(ram_op_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i), .ram_success_i(ram_success_i),
        .stall_o(stall_o), .timeout_o(timeout_o)
    );

    always #10 clk50 = ~clk50;

    // Advance one cycle; the SRAM controller answers sram_lat cycles after op first appears.
    task automatic tick;
        @(posedge clk50);
        #1;
        cyc++;
        if (ram_op_o != 4'b0000) sram_age++; else sram_age = 0;
        ram_success_i = (ram_op_o != 4'b0000) && (sram_age == sram_lat + 1);
        if (!ram_success_i && noise_en && ram_op_o == 4'b0000 && $urandom_range(0, 3) == 0)
            ram_success_i = 1'b1;
        ram_rdata_i = ram_success_i ? sram_data : $urandom;
    endtask

    task automatic clear_inputs;
        inst_req_i   = 1'b0;
        inst_addr_i  = '0;
        data_op_i    = 4'b0000;
        data_addr_i  = '0;
        data_wdata_i = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        noise_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        ram_success_i = 1'b0;
        ram_rdata_i   = 32'h0;
        tick();
        n_vec++;
        if ({ram_op_o, ram_addr_o, ram_wdata_o, inst_rdata_o, inst_ready_o, data_rdata_o,
             data_ready_o, timeout_o, stall_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got op=%h addr=%h rdy=%b/%b to=%b stall=%b, expected all zero",
                     ram_op_o, ram_addr_o, inst_ready_o, data_ready_o, timeout_o, stall_o);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        sram_lat  = 1;
        sram_data = 32'h3C01ABCD;
        tick();
        inst_req_i  = 1'b1;
        inst_addr_i = 20'h00010;
        #1;
        n_vec++;
        if (stall_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall: got %b expected 1", stall_o); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            case (i)
                1: begin
                    n_vec++;
                    if (ram_op_o !== OP_LW || ram_addr_o !== 20'h00010) begin
                        n_bad++;
                        $display("FAIL fetch_op: got op=%h addr=%h expected op=%h addr=00010", ram_op_o, ram_addr_o, OP_LW);
                    end
                end
                3: begin
                    n_vec++;
                    if (inst_ready_o !== 1'b1 || inst_rdata_o !== 32'h3C01ABCD || ram_op_o !== 4'b0000 || data_ready_o !== 1'b0) begin
                        n_bad++;
                        $display("FAIL fetch_ready: got rdy=%b rdata=%h op=%h expected rdy=1 rdata=3c01abcd op=0",
                                 inst_ready_o, inst_rdata_o, ram_op_o);
                    end
                    inst_req_i = 1'b0;
                end
                default: begin
                    n_vec++;
                    if (inst_ready_o !== 1'b0) begin n_bad++; $display("FAIL fetch_noready_c%0d: got %b expected 0", i, inst_ready_o); end
                end
            endcase
        end
    endtask

    task automatic test_priority;
        sram_lat  = 1;
        sram_data = 32'h0BADF00D;
        tick();
        data_op_i    = OP_SW;
        data_addr_i  = 20'h00020;
        data_wdata_i = 32'hDEADBEEF;
        inst_req_i   = 1'b1;
        inst_addr_i  = 20'h00044;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_vec++;
            if (stall_o !== (i < 7)) begin n_bad++; $display("FAIL prio_stall_c%0d: got %b expected %b", i, stall_o, (i < 7)); end
            if (i == 1) begin
                n_vec++;
                if (ram_op_o !== OP_SW || ram_wdata_o !== 32'hDEADBEEF || ram_addr_o !== 20'h00020) begin
                    n_bad++;
                    $display("FAIL prio_data_first: got op=%h wdata=%h addr=%h expected op=%h wdata=deadbeef addr=00020",
                             ram_op_o, ram_wdata_o, ram_addr_o, OP_SW);
                end
            end else if (i == 3) begin
                n_vec++;
                if (data_ready_o !== 1'b1 || inst_ready_o !== 1'b0 || ram_op_o !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL prio_data_ready: got d=%b i=%b op=%h expected d=1 i=0 op=0", data_ready_o, inst_ready_o, ram_op_o);
                end
                data_op_i = 4'b0000;
            end else if (i == 5) begin
                n_vec++;
                if (ram_op_o !== OP_LW || ram_addr_o !== 20'h00044) begin
                    n_bad++;
                    $display("FAIL prio_fetch_second: got op=%h addr=%h expected op=%h addr=00044", ram_op_o, ram_addr_o, OP_LW);
                end
            end else if (i == 7) begin
                n_vec++;
                if (inst_ready_o !== 1'b1 || data_ready_o !== 1'b0 || inst_rdata_o !== 32'h0BADF00D) begin
                    n_bad++;
                    $display("FAIL prio_fetch_ready: got i=%b d=%b rdata=%h expected i=1 d=0 rdata=0badf00d",
                             inst_ready_o, data_ready_o, inst_rdata_o);
                end
                inst_req_i = 1'b0;
            end
        end
    endtask

    task automatic test_timeout;
        sram_lat = 99;
        tick();
        data_op_i   = OP_LW;
        data_addr_i = 20'h00ABC;
        for (int i = 1; i <= 17; i++) begin
            tick();
            n_vec++;
            if (i <= TO) begin
                if (ram_op_o !== OP_LW || data_ready_o !== 1'b0 || timeout_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timeout_busy_c%0d: got op=%h rdy=%b to=%b expected op=%h rdy=0 to=0", i, ram_op_o, data_ready_o, timeout_o, OP_LW);
                end
            end else if (i == TO + 1) begin
                if (timeout_o !== 1'b1 || data_ready_o !== 1'b1 || data_rdata_o !== 32'h0 || ram_op_o !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL timeout_abort: got to=%b rdy=%b rdata=%h op=%h expected to=1 rdy=1 rdata=0 op=0",
                             timeout_o, data_ready_o, data_rdata_o, ram_op_o);
                end
                data_op_i = 4'b0000;
            end else begin
                if (timeout_o !== 1'b0 || data_ready_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timeout_after: got to=%b rdy=%b expected 0 0", timeout_o, data_ready_o);
                end
            end
        end
    endtask

    task automatic test_addr_hold;
        sram_lat  = 3;
        sram_data = 32'h12345678;
        tick();
        data_op_i   = OP_LW;
        data_addr_i = 20'h00123;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_vec++;
            if (i <= 4) begin
                if (ram_addr_o !== 20'h00123 || ram_op_o !== OP_LW) begin
                    n_bad++;
                    $display("FAIL addr_hold_c%0d: got addr=%h op=%h expected addr=00123 op=%h", i, ram_addr_o, ram_op_o, OP_LW);
                end
                data_addr_i = AW'($urandom);
            end else begin
                if (data_ready_o !== 1'b1 || data_rdata_o !== 32'h12345678) begin
                    n_bad++;
                    $display("FAIL addr_hold_ready: got rdy=%b rdata=%h expected rdy=1 rdata=12345678", data_ready_o, data_rdata_o);
                end
                data_op_i = 4'b0000;
            end
        end
    endtask

    task automatic test_reset_mid;
        sram_lat = 99;
        tick();
        data_op_i    = OP_SW;
        data_addr_i  = 20'h00777;
        data_wdata_i = $urandom;
        tick();
        tick();
        n_vec++;
        if (ram_op_o !== OP_SW) begin n_bad++; $display("FAIL rstmid_busy: got op=%h expected %h", ram_op_o, OP_SW); end
        #5;
        rst       = 1'b1;
        data_op_i = 4'b0000;
        #1;
        n_vec++;
        if ({ram_op_o, ram_addr_o, ram_wdata_o, inst_rdata_o, inst_ready_o, data_rdata_o, data_ready_o, timeout_o} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: got op=%h addr=%h wdata=%h irdata=%h drdata=%h expected all zero",
                     ram_op_o, ram_addr_o, ram_wdata_o, inst_rdata_o, data_rdata_o);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_vec++;
            if ({inst_ready_o, data_ready_o, timeout_o} !== 3'b000 || ram_op_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL rstmid_quiet_c%0d: got rdy=%b%b to=%b op=%h expected zeros", i, inst_ready_o, data_ready_o, timeout_o, ram_op_o);
            end
        end
    endtask

    task automatic test_contend;
        bit last_d;
        bit exp_d;
        do_reset();
        sram_lat = 1;
        last_d   = 1'b0;
        exp_d    = 1'b1;
        tick();
        inst_req_i   = 1'b1;
        inst_addr_i  = 20'h00100;
        data_op_i    = 4'b0011;
        data_addr_i  = 20'h00200;
        for (int n = 0; n < 4; n++) begin
            for (int i = 1; i <= 4; i++) begin
                tick();
                if (i == 1) begin
`ifdef SRAM_ARB_RR_EN
                    exp_d = ~last_d;
`else
                    exp_d = 1'b1;
`endif
                    last_d = exp_d;
                    n_vec++;
                    if (ram_op_o !== (exp_d ? 4'b0011 : OP_LW)) begin
                        n_bad++;
                        $display("FAIL contend_grant_%0d: got op=%h expected %h", n, ram_op_o, (exp_d ? 4'b0011 : OP_LW));
                    end
                end else if (i == 3) begin
                    n_vec++;
                    if ({data_ready_o, inst_ready_o} !== {exp_d, ~exp_d}) begin
                        n_bad++;
                        $display("FAIL contend_ready_%0d: got d=%b i=%b expected d=%b i=%b", n, data_ready_o, inst_ready_o, exp_d, ~exp_d);
                    end
                end
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random;
        bit          m_has, m_port_d, m_to, m_last_d, in_op, done, pick_d, exp_stall;
        int          m_t, m_k, m_free_at, c, r;
        logic [3:0]  m_op, exp_op;
        logic [AW-1:0] m_addr;
        logic [31:0] m_wdata, m_rdata, got, expv;
        do_reset();
        noise_en  = 1'b1;
        m_has     = 1'b0;
        m_port_d  = 1'b0;
        m_to      = 1'b0;
        m_last_d  = 1'b0;
        m_t = 0; m_k = 0;
        m_op = 4'b0000; m_addr = '0; m_wdata = 32'h0; m_rdata = 32'h0;
        m_free_at = cyc + 1;
        for (int n = 0; n < 3000; n++) begin
            tick();
            c     = cyc;
            in_op = m_has && (c > m_t) && (c <= m_t + m_k);
            done  = m_has && (c == m_t + m_k + 1);
            exp_op = in_op ? m_op : 4'b0000;
            n_vec++;
            if (ram_op_o !== exp_op) begin n_bad++; $display("FAIL rnd_op cyc %0d: got %h expected %h", c, ram_op_o, exp_op); end
            if (in_op) begin
                n_vec++;
                if (ram_addr_o !== m_addr || (m_port_d && ram_wdata_o !== m_wdata)) begin
                    n_bad++;
                    $display("FAIL rnd_addr cyc %0d: got addr=%h wdata=%h expected addr=%h wdata=%h", c, ram_addr_o, ram_wdata_o, m_addr, m_wdata);
                end
            end
            n_vec++;
            if ({inst_ready_o, data_ready_o, timeout_o} !== {done && !m_port_d, done && m_port_d, done && m_to}) begin
                n_bad++;
                $display("FAIL rnd_pulse cyc %0d: got i=%b d=%b to=%b expected i=%b d=%b to=%b", c, inst_ready_o, data_ready_o,
                         timeout_o, done && !m_port_d, done && m_port_d, done && m_to);
            end
            if (done) begin
                got  = m_port_d ? data_rdata_o : inst_rdata_o;
                expv = m_to ? 32'h0 : m_rdata;
                n_vec++;
                if (got !== expv) begin n_bad++; $display("FAIL rnd_rdata cyc %0d: got %h expected %h", c, got, expv); end
            end
            // Requester behaviour: drop or replace on ready, random new requests, address jitter.
            if (done && !m_port_d) begin
                if ($urandom_range(0, 1) == 0) inst_req_i = 1'b0; else inst_addr_i = AW'($urandom);
            end
            if (done && m_port_d) begin
                if ($urandom_range(0, 1) == 0) data_op_i = 4'b0000;
                else begin data_op_i = 4'($urandom_range(1, 15)); data_addr_i = AW'($urandom); data_wdata_i = $urandom; end
            end
            if (!inst_req_i && $urandom_range(0, 3) == 0) begin inst_req_i = 1'b1; inst_addr_i = AW'($urandom); end
            if (data_op_i == 4'b0000 && $urandom_range(0, 3) == 0) begin
                data_op_i = 4'($urandom_range(1, 15)); data_addr_i = AW'($urandom); data_wdata_i = $urandom;
            end
            if ($urandom_range(0, 7) == 0) data_addr_i = AW'($urandom);
            // Reference schedule: a grant in idle cycle c occupies the SRAM for k cycles, answers at c+k+1.
            if (c >= m_free_at && (inst_req_i || data_op_i != 4'b0000)) begin
`ifdef SRAM_ARB_RR_EN
                pick_d = (data_op_i != 4'b0000) && (!inst_req_i || !m_last_d);
`else
                pick_d = (data_op_i != 4'b0000);
`endif
                m_last_d = pick_d;
                m_port_d = pick_d;
                m_op     = pick_d ? data_op_i : OP_LW;
                m_addr   = pick_d ? data_addr_i : inst_addr_i;
                m_wdata  = data_wdata_i;
                r = $urandom_range(0, 9);
                sram_lat = (r < 6) ? $urandom_range(0, 3) : (r < 9) ? $urandom_range(4, 20) : 99;
                if (sram_lat + 1 <= TO) begin m_k = sram_lat + 1; m_to = 1'b0; end
                else begin m_k = TO; m_to = 1'b1; end
                sram_data = $urandom;
                m_rdata   = sram_data;
                m_t       = c;
                m_has     = 1'b1;
                m_free_at = c + m_k + 2;
            end
            #1;
            exp_stall = (inst_req_i && !(done && !m_port_d)) || ((data_op_i != 4'b0000) && !(done && m_port_d));
            n_vec++;
            if (stall_o !== exp_stall) begin n_bad++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", c, stall_o, exp_stall); end
        end
        noise_en = 1'b0;
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_timeout();
        test_addr_hold();
        test_reset_mid();
        test_contend();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-master arbiter in front of the single-port SRAM controller.
- Shares the controller between the instruction-fetch port (read-only, word) and the data-memory port (all load/store ops per defines.v `MEM_*`).
- Holds one transaction at a time and sequences the controller's op/idle handshake.
- Provides a stall source for the pipeline and a timeout guard.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- TIMEOUT_CYCLES, 15, maximum busy-state cycles waiting for ram_success_i before abort (1..255).

Ports:
- clk50  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- inst_req_i  in  1  fetch request; held high until inst_ready_o.
- inst_addr_i  in  ADDR_W  fetch address.
- inst_rdata_o  out  32  fetched word, valid while inst_ready_o=1.
- inst_ready_o  out  1  one-cycle completion pulse for fetch.
- data_op_i  in  4  `MEM_*` op code; 4'b0 = no request; held until data_ready_o.
- data_addr_i  in  ADDR_W  data address.
- data_wdata_i  in  32  store data.
- data_rdata_o  out  32  load result, valid while data_ready_o=1.
- data_ready_o  out  1  one-cycle completion pulse for data.
- ram_op_o  out  4  op to SRAM controller; 0 = idle.
- ram_addr_o  out  ADDR_W  address to SRAM controller.
- ram_wdata_o  out  32  store data to SRAM controller.
- ram_rdata_i  in  32  controller load data, valid when ram_success_i=1.
- ram_success_i  in  1  controller completion (combinational, one cycle).
- stall_o  out  1  high when any requester is pending without ready this cycle.
- timeout_o  out  1  one-cycle pulse on aborted transaction.

Behaviour:
- Reset (async): state=IDLE, ram_op_o=0, ram_addr_o=0, ram_wdata_o=0, all rdata/ready/timeout outputs=0, timeout counter=0.
- States: IDLE, BUSY_I, BUSY_D, RELEASE.
- IDLE:
  - If data_op_i!=0: capture op/addr/wdata into internal regs, go BUSY_D.
  - Else if inst_req_i: capture addr with op=`MEM_LW, go BUSY_I.
  - ram_op_o=0 in IDLE. Fixed priority: data over fetch.
- BUSY_I/BUSY_D:
  - ram_op_o/addr/wdata driven from the captured regs (registered outputs, stable for the whole transaction).
  - Counter increments each cycle.
  - On ram_success_i=1: register ram_rdata_i into the granted port's rdata output, pulse that port's ready in the next cycle, go RELEASE.
  - If counter reaches TIMEOUT_CYCLES without success: rdata=0, pulse ready and timeout_o next cycle, go RELEASE.
- RELEASE: ram_op_o=0 for exactly one cycle, which returns the controller to idle. Ready/timeout pulse is visible in this cycle. Counter cleared. Next state IDLE.
- Read latency: request seen in cycle 0 → ready in cycle (success cycle + 1). With a controller answering one cycle after op is applied, ready is in cycle 3. Next request is accepted in cycle 4.
- Requester inputs are ignored outside IDLE. Changes during BUSY do not affect the captured transaction.
- Requester must drop or replace its request on the clock edge ending the ready cycle. A request still asserted in IDLE is a new transaction.
- Ready pulses never overlap. inst_ready_o and data_ready_o are never simultaneously high.
- stall_o (combinational) = (inst_req_i & ~inst_ready_o) | ((data_op_i!=0) & ~data_ready_o).
- ram_success_i outside BUSY states is ignored.
- Reset mid-transaction: immediate return to IDLE with ram_op_o=0. No ready pulse is generated.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined: when both ports request in IDLE, grant alternates. A 1-bit last-grant register is updated on each grant and reset to "fetch", so the first tie goes to data.
- Undefined: fixed data-over-fetch priority, and fetch may starve while data keeps requesting.

Test Plan:
- Fetch only, inst_addr_i=20'h00010, model returns 32'h3C01ABCD one cycle after op → ram_op_o=`MEM_LW at cycle 1, inst_ready_o=1 with inst_rdata_o=32'h3C01ABCD at cycle 3, ram_op_o=0 at cycle 3.
- Simultaneous fetch and `MEM_SW` to 20'h00020 with data 32'hDEADBEEF → data served first (ram_wdata_o=32'hDEADBEEF), data_ready_o pulse, one RELEASE cycle, then fetch served. stall_o stays high until the fetch ready.
- Model never asserts success → after 15 BUSY cycles, timeout_o=1 and data_ready_o=1 with data_rdata_o=0, then IDLE.
- rst asserted during BUSY_D → ram_op_o=0 and all outputs 0 asynchronously. No ready pulse after rst release.
- Data requester changes data_addr_i during BUSY → ram_addr_o holds the captured address.
- SRAM_ARB_RR_EN defined, both ports continuously requesting → grants alternate data, fetch, data, fetch over 4 transactions. Without the macro, only data is granted.
